// File: rtl/commit_monitor_pkg.sv
// Shared definitions for the commit monitor: default PC width, FSM state
// encodings and the PC alignment mask.
package commit_monitor_pkg;

    localparam int unsigned DEF_PC_WIDTH = 32;
    localparam int unsigned STATE_W      = 2;
    localparam int unsigned ALIGN_W      = 2;

    // Low PC bits that must be zero for a legally aligned instruction
    localparam logic [ALIGN_W-1:0] PC_ALIGN_MASK = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } mon_state_e;

    function automatic logic pc_misaligned(input logic [ALIGN_W-1:0] pc_lsb);
        return (pc_lsb & PC_ALIGN_MASK) != '0;
    endfunction

endpackage

// File: rtl/commit_monitor_trace_fifo.sv
// Registered (non fall-through) trace FIFO with extra-MSB pointers and a
// synchronous flush; the head is forced to zero whenever the FIFO is empty.
module trace_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr;
    logic              w_rd;

    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A full FIFO still takes a write when the head leaves in the same cycle
    assign w_rd = pop_i && !empty_o && !flush_i;
    assign w_wr = push_i && (!full_o || w_rd) && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
    end

    // Stale storage is never exposed: an empty FIFO presents all zeros
    assign rdata_o = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/commit_monitor.sv
// Retire-stream monitor: checks PC continuity and alignment of each commit,
// queues {pc, next pc, err} into a trace FIFO and keeps sticky status.
module commit_monitor #(
    parameter int unsigned PC_WIDTH  = commit_monitor_pkg::DEF_PC_WIDTH,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic                 halt_on_err_i,
    input  logic                 commit_i,
    input  logic [PC_WIDTH-1:0]  commit_pc_i,
    input  logic [PC_WIDTH-1:0]  commit_pre_pc_i,
    output logic                 trace_valid_o,
    input  logic                 trace_ready_i,
    output logic [PC_WIDTH-1:0]  trace_pc_o,
    output logic [PC_WIDTH-1:0]  trace_npc_o,
    output logic                 trace_err_o,
    output logic [CNT_WIDTH-1:0] commit_cnt_o,
    output logic                 err_o,
    output logic [PC_WIDTH-1:0]  err_pc_o,
    output logic                 ovf_o,
    output logic [1:0]           state_o
);

    import commit_monitor_pkg::*;

    localparam int unsigned ENTRY_W = 2 * PC_WIDTH + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("commit_monitor: DEPTH must be a power of two >= 2");
    end

    mon_state_e            r_state;
    mon_state_e            w_state_nxt;
    logic                  w_in_idle;
    logic                  w_in_run;

    logic                  r_pred_valid;
    logic [PC_WIDTH-1:0]   r_pred_npc;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_err;
    logic [PC_WIDTH-1:0]   r_err_pc;
    logic                  r_ovf;

    logic                  w_enter_run;
    logic                  w_cap;
    logic                  w_cont_err;
    logic                  w_align_err;
    logic                  w_err;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [ENTRY_W-1:0]    w_wdata;
    logic [ENTRY_W-1:0]    w_rdata;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state; clear wins over every other event
    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (enable_i)                         w_state_nxt = ST_RUN;
                ST_RUN:  if (w_cap && w_err && halt_on_err_i)  w_state_nxt = ST_HALT;
                ST_HALT: w_state_nxt = ST_HALT;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State decodes
    always_comb begin
        w_in_idle = 1'b0;
        w_in_run  = 1'b0;
        state_o   = r_state;
        case (r_state)
            ST_IDLE: w_in_idle = 1'b1;
            ST_RUN:  w_in_run  = 1'b1;
            default: ;
        endcase
    end

    assign w_enter_run = w_in_idle && enable_i && !clear_i;
    assign w_cap       = w_in_run && commit_i && !clear_i;

    assign w_cont_err  = r_pred_valid && (commit_pc_i != r_pred_npc);
    assign w_align_err = pc_misaligned(commit_pc_i[ALIGN_W-1:0]) ||
                         pc_misaligned(commit_pre_pc_i[ALIGN_W-1:0]);
    assign w_err       = w_cont_err || w_align_err;

    assign w_pop  = trace_valid_o && trace_ready_i && !clear_i;
    assign w_push = w_cap && (!w_full || w_pop);
    assign w_drop = w_cap && w_full && !w_pop;

    assign w_wdata = {commit_pc_i, commit_pre_pc_i, w_err};

    trace_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_trace_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (clear_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (w_wdata),
        .rdata_o (w_rdata),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Predecessor tracks the CPU stream, so dropped or erroneous commits still update it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pred_valid <= 1'b0;
            r_pred_npc   <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_err_pc     <= '0;
            r_ovf        <= 1'b0;
        end else if (clear_i) begin
            r_pred_valid <= 1'b0;
            r_pred_npc   <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_err_pc     <= '0;
            r_ovf        <= 1'b0;
        end else begin
            if (w_enter_run) begin
                r_pred_valid <= 1'b0;
            end else if (w_cap) begin
                r_pred_valid <= 1'b1;
                r_pred_npc   <= commit_pre_pc_i;
            end
            if (w_push) r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (w_cap && w_err && !r_err) begin
                r_err    <= 1'b1;
                r_err_pc <= commit_pc_i;
            end
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign trace_valid_o = !w_empty;
    assign trace_pc_o    = w_rdata[ENTRY_W-1 -: PC_WIDTH];
    assign trace_npc_o   = w_rdata[PC_WIDTH:1];
    assign trace_err_o   = w_rdata[0];
    assign commit_cnt_o  = r_cnt;
    assign err_o         = r_err;
    assign err_pc_o      = r_err_pc;
    assign ovf_o         = r_ovf;

endmodule

// File: tb/tb_commit_monitor.sv
// Directed self-checking bench for commit_monitor (DEPTH=8, 32-bit PCs).
`timescale 1ns/1ps
module tb_commit_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic        clear_i;
    logic        halt_on_err_i;
    logic        commit_i;
    logic [31:0] commit_pc_i;
    logic [31:0] commit_pre_pc_i;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_pc_o;
    logic [31:0] trace_npc_o;
    logic        trace_err_o;
    logic [31:0] commit_cnt_o;
    logic        err_o;
    logic [31:0] err_pc_o;
    logic        ovf_o;
    logic [1:0]  state_o;

    int n_cmp = 0;
    int n_err = 0;

    commit_monitor dut (
        .clk             (clk),
        .rst             (rst),
        .enable_i        (enable_i),
        .clear_i         (clear_i),
        .halt_on_err_i   (halt_on_err_i),
        .commit_i        (commit_i),
        .commit_pc_i     (commit_pc_i),
        .commit_pre_pc_i (commit_pre_pc_i),
        .trace_valid_o   (trace_valid_o),
        .trace_ready_i   (trace_ready_i),
        .trace_pc_o      (trace_pc_o),
        .trace_npc_o     (trace_npc_o),
        .trace_err_o     (trace_err_o),
        .commit_cnt_o    (commit_cnt_o),
        .err_o           (err_o),
        .err_pc_o        (err_pc_o),
        .ovf_o           (ovf_o),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        commit_i = 1'b0;
        clear_i  = 1'b1;
        tick();
        clear_i  = 1'b0;
        chk("clear_state", 64'(state_o), 64'd0);
        chk("clear_cnt", 64'(commit_cnt_o), 64'd0);
        enable_i = 1'b1;
        tick();
        chk("enter_run", 64'(state_o), 64'd1);
    endtask

    task automatic do_commit(input logic [31:0] pc, input logic [31:0] npc);
        commit_i        = 1'b1;
        commit_pc_i     = pc;
        commit_pre_pc_i = npc;
        tick();
        commit_i        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; enable_i = 1'b0; clear_i = 1'b0; halt_on_err_i = 1'b0;
        commit_i = 1'b0; commit_pc_i = '0; commit_pre_pc_i = '0; trace_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_valid", 64'(trace_valid_o), 64'd0);
        chk("rst_pc", 64'(trace_pc_o), 64'd0);
        chk("rst_cnt", 64'(commit_cnt_o), 64'd0);
        chk("rst_err", 64'({err_o, ovf_o}), 64'd0);
        rst = 1'b1;
        tick();

        // Clean sequential stream, consumer always ready
        enable_i = 1'b1; trace_ready_i = 1'b1;
        tick();
        chk("a_run", 64'(state_o), 64'd1);
        do_commit(32'h0, 32'h4);
        chk("a_h0_pc", 64'({trace_valid_o, trace_pc_o, trace_npc_o, trace_err_o}), {31'd0, 1'b1, 32'h0, 32'h4, 1'b0});
        do_commit(32'h4, 32'h8);
        chk("a_h1_pc", 64'({trace_pc_o, trace_err_o}), {32'h4, 1'b0});
        do_commit(32'h8, 32'hC);
        chk("a_h2_pc", 64'({trace_pc_o, trace_npc_o, trace_err_o}), {32'h8, 32'hC, 1'b0});
        chk("a_cnt", 64'(commit_cnt_o), 64'd3);
        chk("a_err", 64'(err_o), 64'd0);
        tick();
        chk("a_drained", 64'(trace_valid_o), 64'd0);

        // Continuity break halts capture
        trace_ready_i = 1'b0; halt_on_err_i = 1'b1;
        start_run();
        do_commit(32'h10, 32'h14);
        do_commit(32'h20, 32'h24);
        chk("b_state", 64'(state_o), 64'd2);
        chk("b_err", 64'(err_o), 64'd1);
        chk("b_err_pc", 64'(err_pc_o), 64'h20);
        do_commit(32'h24, 32'h28);
        chk("b_cnt", 64'(commit_cnt_o), 64'd2);
        chk("b_h0", 64'({trace_pc_o, trace_err_o}), {32'h10, 1'b0});
        trace_ready_i = 1'b1;
        tick();
        chk("b_h1", 64'({trace_pc_o, trace_npc_o, trace_err_o}), {32'h20, 32'h24, 1'b1});
        tick();
        chk("b_no_third", 64'(trace_valid_o), 64'd0);

        // Overflow with stalled consumer
        trace_ready_i = 1'b0; halt_on_err_i = 1'b0;
        start_run();
        for (int i = 0; i < 10; i++) do_commit(32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i));
        chk("c_cnt", 64'(commit_cnt_o), 64'd8);
        chk("c_ovf", 64'(ovf_o), 64'd1);
        chk("c_err", 64'(err_o), 64'd0);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("c_drain%0d", i), 64'(trace_pc_o), 64'(32'h100 + 32'(4 * i)));
            tick();
        end
        chk("c_empty", 64'(trace_valid_o), 64'd0);

        // Full FIFO, push and pop together
        trace_ready_i = 1'b0;
        start_run();
        for (int i = 0; i < 8; i++) do_commit(32'h200 + 32'(4 * i), 32'h204 + 32'(4 * i));
        chk("d_cnt8", 64'(commit_cnt_o), 64'd8);
        trace_ready_i = 1'b1;
        do_commit(32'h220, 32'h224);
        trace_ready_i = 1'b0;
        chk("d_ovf", 64'(ovf_o), 64'd0);
        chk("d_cnt9", 64'(commit_cnt_o), 64'd9);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("d_drain%0d", i), 64'({trace_valid_o, trace_pc_o}), 64'({1'b1, 32'h204 + 32'(4 * i)}));
            tick();
        end
        chk("d_empty", 64'(trace_valid_o), 64'd0);

        // Misaligned first commit
        trace_ready_i = 1'b0;
        start_run();
        do_commit(32'h6, 32'h8);
        chk("e_head_err", 64'({trace_pc_o, trace_err_o}), {32'h6, 1'b1});
        chk("e_err", 64'({err_o, err_pc_o}), {1'b1, 32'h6});
        chk("e_state", 64'(state_o), 64'd1);

        // Asynchronous reset with entries queued
        start_run();
        for (int i = 0; i < 5; i++) do_commit(32'h300 + 32'(4 * i), 32'h304 + 32'(4 * i));
        chk("f_cnt5", 64'(commit_cnt_o), 64'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("f_rst_valid", 64'({trace_valid_o, trace_pc_o, trace_npc_o, trace_err_o}), 64'd0);
        chk("f_rst_stat", 64'({commit_cnt_o, err_o, ovf_o, state_o}), 64'd0);
        tick();
        rst = 1'b1;
        chk("f_idle", 64'(state_o), 64'd0);
        tick();
        chk("f_run", 64'(state_o), 64'd1);
        do_commit(32'h400, 32'h404);
        chk("f_first", 64'({trace_valid_o, trace_pc_o, trace_err_o}), {31'd0, 1'b1, 32'h400, 1'b0});
        chk("f_first_err", 64'({commit_cnt_o, err_o}), {32'd1, 1'b0});
        do_commit(32'h500, 32'h504);
        chk("f_second_err", 64'({err_o, err_pc_o}), {1'b1, 32'h500});
        chk("f_cnt2", 64'(commit_cnt_o), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
